rf_wb_arbiter: RTL

Round-robin arbiter that shares the register file's single write port among `NUM_REQ` writeback requesters, e.g. ALU result, load return and a multi-cycle mul/div unit. It grants at most one requester per cycle through a valid/ready handshake and registers the winning write. It then drives the regfile's `rd_addr`/`rd_data`/`RegWEn` inputs one cycle later. Writes to register 0 are accepted and discarded.

---
 rtl/rf_wb_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Round-robin arbiter sharing the register file's single write port among
// NUM_REQ writeback requesters (ALU, load return, mul/div, ...). At most one
// requester is granted per cycle through a valid/ready handshake. The winning
// write is registered and presented to the regfile one cycle later. Writes to
// register 0 complete the handshake but never raise RegWEn.
//
// Ports:
//   clk        single clock, rising-edge
//   rst_n      asynchronous active-low reset
//   stall      suppresses new grants while high
//   req_valid  per-requester write pending
//   req_addr   flat bus, slice i = requester i's destination register
//   req_data   flat bus, slice i = requester i's write data
//   req_ready  one-hot (or zero) grant, combinational
//   rd_addr    registered write address to the regfile
//   rd_data    registered write data to the regfile
//   RegWEn     registered write enable to the regfile
//   grant_id   registered index of the last accepted requester (debug)
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int REG_DATA_WIDTH = 16,
    parameter int NUM_REQ        = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               stall,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*REG_DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [REG_ADDR_WIDTH-1:0]          rd_addr,
    output logic [REG_DATA_WIDTH-1:0]          rd_data,
    output logic                               RegWEn,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_DATA_WIDTH-1:0] data_q, data_d;
    logic                      we_q, we_d;
    logic [IDX_W-1:0]          gid_q, gid_d;

    logic [REG_ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [REG_DATA_WIDTH-1:0] data_arr [NUM_REQ];

    logic                      win_vld;
    logic [IDX_W-1:0]          win_idx;
    logic                      xfer;

    // Unpack the flat request buses so the winner can be selected by index.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            data_arr[i] = req_data[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
        end
    end

    // Scan from ptr upward, wrapping modulo NUM_REQ; first valid wins.
    // ptr + k never exceeds 2*NUM_REQ-2, so one conditional subtract
    // is enough to wrap.
    always_comb begin : arbitrate
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!win_vld && req_valid[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign xfer = win_vld & ~stall;

    // Ready is held low throughout reset even though ptr is already 0.
    always_comb begin
        req_ready = '0;
        if (xfer && rst_n) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        addr_d = addr_q;
        data_d = data_q;
        gid_d  = gid_q;
        we_d   = 1'b0;
        if (xfer) begin
            addr_d = addr_arr[win_idx];
            data_d = data_arr[win_idx];
            gid_d  = win_idx;
            // Register 0 is hardwired: accept the write, never enable it.
            we_d   = |addr_arr[win_idx];
            ptr_d  = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            gid_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            addr_q <= addr_d;
            data_q <= data_d;
            we_q   <= we_d;
            gid_q  <= gid_d;
        end
    end

    assign rd_addr  = addr_q;
    assign rd_data  = data_q;
    assign RegWEn   = we_q;
    assign grant_id = gid_q;

endmodule
